// File: rtl/qmac_pkg.sv
// qmac_pkg: shared sign-magnitude type, width helpers and accumulator state for the qmac pipeline
//   sm_t        wide sign-magnitude value used as the common adder format
//   acc_state_t accumulator state (IDLE = acc is +0, ACC = partial sum held)
//   pw_of/aw_of product and accumulator magnitude widths
//   sm_add      sign-magnitude add, zero result forced to +0
package qmac_pkg;
   localparam int SMW = 48;
   typedef struct packed {
      logic sign;
      logic [SMW-1:0] mag;
   } sm_t;
   typedef enum logic {IDLE, ACC} acc_state_t;
   function automatic int pw_of(input int n);
      return 2 * n - 2;
   endfunction
   function automatic int aw_of(input int n, input int g);
      return n - 1 + g;
   endfunction
   function automatic sm_t sm_add(input sm_t a, input sm_t b);
      sm_t r;
      logic a_big;
      a_big = a.mag >= b.mag;
      r.mag = (a.sign == b.sign) ? a.mag + b.mag : a_big ? a.mag - b.mag : b.mag - a.mag;
      r.sign = (a_big ? a.sign : b.sign) && (r.mag != '0);
      return r;
   endfunction
endpackage

// File: rtl/qmult_pipe.sv
// qmult_pipe: two-stage sign-magnitude Q multiplier (multiply, then round/clamp with overflow flag)
//   i_clk, i_rst       clock, async active-high reset
//   i_en               advance both stages
//   i_valid/first/last operand tags, carried alongside the product
//   i_multiplicand/_multiplier  N-bit sign-magnitude operands
//   o_valid/first/last tags of the stage-2 product
//   o_sign, o_mag, o_ovf  product sign, N-1 bit magnitude, product overflow
module qmult_pipe import qmac_pkg::*; #(
   parameter int N = 16,
   parameter int Q = 12,
   parameter bit SAT = 1'b1,
   parameter bit RND = 1'b0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic         i_valid,
   input  logic         i_first,
   input  logic         i_last,
   input  logic [N-1:0] i_multiplicand,
   input  logic [N-1:0] i_multiplier,
   output logic         o_valid,
   output logic         o_first,
   output logic         o_last,
   output logic         o_sign,
   output logic [N-2:0] o_mag,
   output logic         o_ovf
);
   localparam int PW = pw_of(N);
   localparam logic [PW:0] HALF = (PW + 1)'(RND) << (Q - 1);
   logic s1_v, s1_f, s1_l, s1_s;
   logic [PW-1:0] s1_p;
   logic [PW:0] m;
   logic m_ovf;
   logic [N-2:0] m_mag;
   always_comb begin
      m = ({1'b0, s1_p} + HALF) >> Q;
      m_ovf = |m[PW:N-1];
      m_mag = (m_ovf && SAT) ? '1 : m[N-2:0];
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         s1_v <= 1'b0;
         s1_f <= 1'b0;
         s1_l <= 1'b0;
         s1_s <= 1'b0;
         s1_p <= '0;
         o_valid <= 1'b0;
         o_first <= 1'b0;
         o_last <= 1'b0;
         o_sign <= 1'b0;
         o_mag <= '0;
         o_ovf <= 1'b0;
      end else if (i_en) begin
         s1_v <= i_valid;
         s1_f <= i_first;
         s1_l <= i_last;
         s1_s <= i_multiplicand[N-1] ^ i_multiplier[N-1];
         s1_p <= PW'(i_multiplicand[N-2:0]) * PW'(i_multiplier[N-2:0]);
         o_valid <= s1_v;
         o_first <= s1_f;
         o_last <= s1_l;
         o_sign <= s1_s && |m_mag;
         o_mag <= m_mag;
         o_ovf <= m_ovf;
      end
endmodule

// File: rtl/qmac_pipe.sv
// qmac_pipe: pipelined sign-magnitude Q multiply-accumulate with guarded accumulator and held result
//   i_clk, i_rst        clock, async active-high reset
//   i_valid, o_ready    operand handshake (transfer on i_valid && o_ready)
//   i_first, i_last     open / close a dot product
//   i_multiplicand/_multiplier  N-bit sign-magnitude operands
//   o_valid, i_out_ready  result handshake
//   o_result, o_ovr     N-bit sign-magnitude result, sticky overflow of that result
module qmac_pipe import qmac_pkg::*; #(
   parameter int Q = 12,
   parameter int N = 16,
   parameter int G = 4,
   parameter bit SAT = 1'b1,
   parameter bit RND = 1'b0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic         i_first,
   input  logic         i_last,
   input  logic [N-1:0] i_multiplicand,
   input  logic [N-1:0] i_multiplier,
   output logic         o_valid,
   input  logic         i_out_ready,
   output logic [N-1:0] o_result,
   output logic         o_ovr
);
   localparam int AW = aw_of(N, G);
   acc_state_t state, state_n;
   logic use_acc;
   logic p_v, p_f, p_l, p_s, p_ovf;
   logic [N-2:0] p_m;
   logic acc_s, sticky;
   logic [AW-1:0] acc_m, sum_m;
   sm_t base, prod, sum;
   logic acc_ovf, sum_s, stk_n, res_ovf;
   logic [N-2:0] res_m;
   logic r_v, r_s, r_o;
   logic [N-2:0] r_m;
   assign o_ready = !(o_valid && !i_out_ready);
   qmult_pipe #(.N(N), .Q(Q), .SAT(SAT), .RND(RND)) u_mult (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(o_ready),
      .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
      .i_multiplicand(i_multiplicand), .i_multiplier(i_multiplier),
      .o_valid(p_v), .o_first(p_f), .o_last(p_l),
      .o_sign(p_s), .o_mag(p_m), .o_ovf(p_ovf)
   );
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) state <= IDLE;
      else state <= state_n;
   always_comb state_n = (o_ready && p_v) ? (p_l ? IDLE : ACC) : state;
   // i_first discards the running sum; IDLE always adds onto +0
   always_comb use_acc = (state == ACC) && !p_f;
   always_comb begin
      base.sign = use_acc && acc_s;
      base.mag = use_acc ? SMW'(acc_m) : '0;
      prod.sign = p_s;
      prod.mag = SMW'(p_m);
      sum = sm_add(base, prod);
      acc_ovf = |sum.mag[SMW-1:AW];
      sum_m = (acc_ovf && SAT) ? '1 : sum.mag[AW-1:0];
      sum_s = sum.sign && |sum_m;
      stk_n = (use_acc && sticky) || p_ovf || acc_ovf;
      res_ovf = |sum_m[AW-1:N-1];
      res_m = (res_ovf && SAT) ? '1 : sum_m[N-2:0];
   end
   // S3 registers the clamped result, then the output register presents it one edge later
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         acc_s <= 1'b0;
         acc_m <= '0;
         sticky <= 1'b0;
         r_v <= 1'b0;
         r_s <= 1'b0;
         r_m <= '0;
         r_o <= 1'b0;
         o_valid <= 1'b0;
         o_result <= '0;
         o_ovr <= 1'b0;
      end else if (o_ready) begin
         if (p_v) begin
            acc_s <= !p_l && sum_s;
            acc_m <= p_l ? '0 : sum_m;
            sticky <= !p_l && stk_n;
         end
         r_v <= p_v && p_l;
         if (p_v && p_l) begin
            r_s <= sum_s && |res_m;
            r_m <= res_m;
            r_o <= stk_n || res_ovf;
         end
         o_valid <= r_v;
         if (r_v) begin
            o_result <= {r_s, r_m};
            o_ovr <= r_o;
         end
      end
endmodule
